dsp_column_carry_resolver: RTL and testbench

//  Consumes the 48-bit column sums produced by a DSP multiply-add cascade,

---
 rtl/dsp_column_carry_resolver.sv | 128 ++++++++++++
 tb/tb_dsp_column_carry_resolver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_column_carry_resolver.sv
// Column-sum to 17-bit limb normaliser: adds each DSP column sum to the running
// carry, emits the low limb, and flushes the leftover carry after the last column.
module dsp_column_carry_resolver #(
   parameter int IN_WIDTH    = 48,
   parameter int LIMB_WIDTH  = 17,
   parameter int NUM_COLS    = 8,
   parameter int FLUSH_LIMBS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_WIDTH-1:0]   in_col,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LIMB_WIDTH-1:0] out_limb,
   output logic [3:0]            out_index,
   output logic                  out_last,
   output logic                  busy
);

   localparam int CW = IN_WIDTH - LIMB_WIDTH + 1;
   localparam logic [3:0] LAST_COL   = 4'(NUM_COLS - 1);
   localparam logic [3:0] LAST_FLUSH = 4'(FLUSH_LIMBS - 1);
   localparam logic [3:0] FLUSH_BASE = 4'(NUM_COLS);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         carry, carry_nxt;
   logic [3:0]            col_cnt, col_cnt_nxt;
   logic [3:0]            flush_cnt, flush_cnt_nxt;
   logic                  slot_free;
   logic                  load;
   logic [LIMB_WIDTH-1:0] limb_nxt;
   logic [3:0]            index_nxt;
   logic                  last_nxt;
   logic [IN_WIDTH:0]     sum;

   // The output register can take a new limb if empty or being drained this cycle.
   assign slot_free = !out_valid || out_ready;
   assign sum       = {1'b0, in_col} + (IN_WIDTH + 1)'(carry);
   assign busy      = (col_cnt != '0) || (flush_cnt != '0);

   always_comb begin
      // NOTE: every signal gets a default here so no path leaves one unassigned,
      // which would otherwise infer a latch.
      state_nxt     = state;
      carry_nxt     = carry;
      col_cnt_nxt   = col_cnt;
      flush_cnt_nxt = flush_cnt;
      load          = 1'b0;
      in_ready      = 1'b0;
      limb_nxt      = '0;
      index_nxt     = '0;
      last_nxt      = 1'b0;

      case (state)
         RUN: begin
            in_ready = slot_free;
            if (in_valid && slot_free) begin
               load      = 1'b1;
               limb_nxt  = sum[LIMB_WIDTH-1:0];
               carry_nxt = sum[IN_WIDTH:LIMB_WIDTH];
               index_nxt = col_cnt;
               if (col_cnt == LAST_COL) begin
                  col_cnt_nxt = '0;
                  state_nxt   = FLUSH;
               end else begin
                  col_cnt_nxt = col_cnt + 4'd1;
               end
            end
         end
         FLUSH: begin
            if (slot_free) begin
               load      = 1'b1;
               limb_nxt  = carry[LIMB_WIDTH-1:0];
               carry_nxt = carry >> LIMB_WIDTH;
               index_nxt = FLUSH_BASE + flush_cnt;
               if (flush_cnt == LAST_FLUSH) begin
                  // Residual carry is provably zero here; clearing it keeps words independent.
                  last_nxt      = 1'b1;
                  carry_nxt     = '0;
                  flush_cnt_nxt = '0;
                  state_nxt     = RUN;
               end else begin
                  flush_cnt_nxt = flush_cnt + 4'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         carry     <= '0;
         col_cnt   <= '0;
         flush_cnt <= '0;
         out_valid <= 1'b0;
         out_limb  <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
      end else begin
         carry     <= carry_nxt;
         col_cnt   <= col_cnt_nxt;
         flush_cnt <= flush_cnt_nxt;
         if (load) begin
            out_valid <= 1'b1;
            out_limb  <= limb_nxt;
            out_index <= index_nxt;
            out_last  <= last_nxt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dsp_column_carry_resolver.sv
// Directed bench for dsp_column_carry_resolver; limbs are compared against a
// wide-integer model of each word (sum of columns shifted by 17*i).
module tb_dsp_column_carry_resolver;

   typedef logic [47:0] word_t [8];

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] in_col;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] out_limb;
   logic [3:0]  out_index;
   logic        out_last;
   logic        busy;

   int errors = 0;
   int checks = 0;

   // Entries are {index[21:18], last[17], limb[16:0]}.
   logic [47:0] cols_q[$];
   logic [21:0] exp_q[$];
   logic [21:0] got_q[$];

   dsp_column_carry_resolver dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_col(in_col), .out_valid(out_valid), .out_ready(out_ready),
      .out_limb(out_limb), .out_index(out_index), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected limbs come from the whole word as one wide integer.
   task automatic push_word(input word_t w);
      logic [169:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++) begin
         acc = acc + (170'(w[i]) << (17 * i));
         cols_q.push_back(w[i]);
      end
      for (int j = 0; j < 10; j++)
         exp_q.push_back({4'(j), (j == 9), acc[17*j +: 17]});
   endtask

   function automatic word_t rand_word();
      word_t w;
      for (int i = 0; i < 8; i++)
         w[i] = ($urandom_range(3) == 0) ? 48'hFFFF_FFFF_FFFF : 48'({$urandom(), $urandom()});
      return w;
   endfunction

   // One cycle: drive at the falling edge, then observe handshakes 1ns later.
   task automatic tick(input bit vin, input bit rdy);
      @(negedge clk);
      in_valid  = vin && (cols_q.size() > 0);
      in_col    = in_valid ? cols_q[0] : 48'({$urandom(), $urandom()});
      out_ready = rdy;
      #1;
      if (in_valid && in_ready) void'(cols_q.pop_front());
      if (out_valid && out_ready) got_q.push_back({out_index, out_last, out_limb});
   endtask

   task automatic run_until(input string tag, input int budget, input int vpct, input int rpct);
      int cyc = 0;
      while (got_q.size() < exp_q.size() && cyc < budget) begin
         tick($urandom_range(99) < vpct, $urandom_range(99) < rpct);
         cyc++;
      end
      check({tag, "_done"}, 64'(got_q.size() >= exp_q.size()), 64'(1));
      repeat (12) tick(1'b0, 1'b1);
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check(tag, 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
      cols_q.delete();
   endtask

   initial begin
      word_t w;
      int    n_last;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_col    = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_limb",  64'(out_limb),  64'(0));
      check("rst_out_index", 64'(out_index), 64'(0));
      check("rst_out_last",  64'(out_last),  64'(0));
      check("rst_busy",      64'(busy),      64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
      reset = 1'b0;

      // All-zero word, in_ready stalls for exactly two flush cycles.
      w = '{default: 48'd0};
      push_word(w);
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, 1'b1);
         check("zero_in_ready_run", 64'(in_ready), 64'(1));
      end
      tick(1'b1, 1'b1);
      check("zero_in_ready_flush0", 64'(in_ready), 64'(0));
      tick(1'b1, 1'b1);
      check("zero_in_ready_flush1", 64'(in_ready), 64'(0));
      tick(1'b1, 1'b1);
      check("zero_in_ready_back", 64'(in_ready), 64'(1));
      run_until("zero", 200, 100, 100);
      compare_all("zero");

      // Single carry step between column 0 and column 1.
      w = '{48'h0000_0002_0005, 48'd3, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0};
      push_word(w);
      run_until("carry", 200, 100, 100);
      if (got_q.size() >= 2) begin
         check("carry_limb0", 64'(got_q[0][16:0]), 64'(5));
         check("carry_limb1", 64'(got_q[1][16:0]), 64'(4));
      end
      compare_all("carry");

      // Saturated columns.
      w = '{default: 48'hFFFF_FFFF_FFFF};
      push_word(w);
      run_until("sat", 200, 100, 100);
      if (got_q.size() >= 2) begin
         check("sat_limb0", 64'(got_q[0][16:0]), 64'(17'h1FFFF));
         check("sat_limb1", 64'(got_q[1][16:0]), 64'(17'h1FFFE));
      end
      compare_all("sat");

      // Backpressure mid-word: output held, input refused.
      push_word(rand_word());
      repeat (3) tick(1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick(1'b1, 1'b0);
         check("bp_in_ready",  64'(in_ready),  64'(0));
         check("bp_out_valid", 64'(out_valid), 64'(1));
         check("bp_out_index", 64'(out_index), 64'(2));
         check("bp_out_limb",  64'(out_limb),  64'(exp_q[2][16:0]));
      end
      run_until("bp", 400, 100, 100);
      compare_all("bp");
      for (int k = 0; k < 3; k++) push_word(rand_word());
      run_until("bp_rand", 2000, 100, 40);
      compare_all("bp_rand");

      // Reset after three columns of a word with a large carry.
      w = '{default: 48'hFFFF_FFFF_FFFF};
      push_word(w);
      repeat (3) tick(1'b1, 1'b1);
      check("mid_busy", 64'(busy), 64'(1));
      reset = 1'b1;
      tick(1'b0, 1'b0);
      reset = 1'b0;
      check("mid_rst_out_valid", 64'(out_valid), 64'(0));
      check("mid_rst_busy",      64'(busy),      64'(0));
      check("mid_rst_out_index", 64'(out_index), 64'(0));
      got_q.delete();
      exp_q.delete();
      cols_q.delete();
      w = '{48'h0000_0002_0005, 48'd3, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0};
      push_word(w);
      run_until("after_rst", 200, 100, 100);
      compare_all("after_rst");

      // Gappy traffic over 100 words.
      for (int k = 0; k < 100; k++) push_word(rand_word());
      run_until("gappy", 40000, 60, 60);
      n_last = 0;
      foreach (got_q[i]) if (got_q[i][17]) n_last++;
      check("gappy_last_count", 64'(n_last), 64'(100));
      compare_all("gappy");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
